// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg: shared state encoding and defaults for the SRAM memory stage
package mem_stage_sram_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int BASE_ADDR_DEF = 1024;
    localparam int REG_W = 4;
endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// sram_ctrl: two half-word access sequencer for a 16-bit async SRAM, with freeze generation
module sram_ctrl
    import mem_stage_sram_pkg::*;
#(
    parameter int BASE_ADDR   = BASE_ADDR_DEF,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd,
    input  logic               wr,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic [31:0]        rd_buf
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    logic [1:0]         state, nxt;
    logic [CW-1:0]      cnt;
    logic [SRAM_AW-2:0] word;
    logic               last, busy, nbusy, req;
    always_comb begin
        word   = (SRAM_AW-1)'((addr - 32'(BASE_ADDR)) >> 2);
        req    = rd || wr;
        last   = cnt == CW'(WAIT_CYCLES - 1);
        busy   = state == S_LO || state == S_HI;
        nxt    = state == S_IDLE ? (req ? S_LO : S_IDLE) :
                 state == S_LO   ? (last ? S_HI : S_LO) :
                 state == S_HI   ? (last ? S_DONE : S_HI) : S_IDLE;
        nbusy  = nxt == S_LO || nxt == S_HI;
        freeze = (state == S_IDLE && req) || busy;
    end
    // Pins are registered from the next state so the async SRAM sees glitch-free strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rd_buf     <= '0;
        end else begin
            state      <= nxt;
            cnt        <= (busy && !last) ? cnt + 1'b1 : '0;
            sram_we_n  <= !(nbusy && wr);
            sram_oe_n  <= !(nbusy && !wr);
            sram_addr  <= nbusy ? {word, nxt == S_HI} : '0;
            sram_wdata <= (nbusy && wr) ? (nxt == S_HI ? wdata[31:16] : wdata[15:0]) : '0;
            if (state == S_LO && last && !wr) rd_buf[15:0] <= sram_rdata;
            if (state == S_HI && last && !wr) rd_buf[31:16] <= sram_rdata;
        end
    end
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: pipeline memory stage over 16-bit async SRAM plus the MEM/WB register
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int BASE_ADDR   = BASE_ADDR_DEF,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_read_en_in,
    input  logic               mem_write_en_in,
    input  logic [31:0]        alu_res_in,
    input  logic [31:0]        val_rm_in,
    input  logic [REG_W-1:0]   dest_in,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               wb_en_out,
    output logic               mem_read_en_out,
    output logic [31:0]        alu_res_out,
    output logic [31:0]        mem_data_out,
    output logic [REG_W-1:0]   dest_out
);
    logic [31:0] rd_buf;
    sram_ctrl #(.BASE_ADDR(BASE_ADDR), .WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .rd(mem_read_en_in),
        .wr(mem_write_en_in),
        .addr(alu_res_in),
        .wdata(val_rm_in),
        .freeze(freeze),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n),
        .rd_buf(rd_buf)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_out       <= 1'b0;
            mem_read_en_out <= 1'b0;
            alu_res_out     <= '0;
            mem_data_out    <= '0;
            dest_out        <= '0;
        end else if (freeze) begin
            wb_en_out       <= 1'b0;
            mem_read_en_out <= 1'b0;
        end else begin
            wb_en_out       <= wb_en_in;
            mem_read_en_out <= mem_read_en_in;
            alu_res_out     <= alu_res_in;
            mem_data_out    <= rd_buf;
            dest_out        <= dest_in;
        end
    end
endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage ARM pipeline. Sits directly downstream of the EXE/MEM pipeline register and consumes its outputs.
- Performs data loads/stores to an external 16-bit asynchronous SRAM. Each 32-bit word takes two half-word accesses, each with a programmable wait time.
- Asserts freeze to stall the whole pipeline while an access is in flight.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM half-word 0.
- WAIT_CYCLES, 2: clock cycles per half-word access; legal range ≥1.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_en_in  in  1  write-back enable from EXE/MEM register.
- mem_read_en_in  in  1  load request.
- mem_write_en_in  in  1  store request.
- alu_res_in  in  32  byte address for memory ops; result for non-memory ops.
- val_rm_in  in  32  store data.
- dest_in  in  4  destination register.
- freeze  out  1  combinational; 1 = stall PC, IF/ID, ID/EX, EXE/MEM.
- sram_addr  out  SRAM_AW  half-word address.
- sram_wdata  out  16  write data.
- sram_rdata  in  16  read data.
- sram_we_n  out  1  active-low write enable.
- sram_oe_n  out  1  active-low output enable.
- wb_en_out  out  1  MEM/WB: write-back enable.
- mem_read_en_out  out  1  MEM/WB: selects mem_data_out in WB mux.
- alu_res_out  out  32  MEM/WB: ALU result.
- mem_data_out  out  32  MEM/WB: loaded word.
- dest_out  out  4  MEM/WB: destination register.

Behaviour:
- Reset: FSM returns to IDLE and the wait counter clears.
  - All MEM/WB outputs become 0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
  - Reset wins over any in-flight access; a write already in progress is abandoned with we_n deasserted the next cycle.
- Address translation: word = (alu_res_in − BASE_ADDR) >> 2, truncated to SRAM_AW−1 bits.
  - Low half address = {word,0}; high half address = {word,1}.
  - Little-endian: low half holds bits [15:0].
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if mem_read_en_in or mem_write_en_in, go to LO with counter=0; otherwise stay. A request with both enables set is treated as a write.
  - LO: drive the low-half address. Stay WAIT_CYCLES cycles, counting 0..WAIT_CYCLES−1, then go to HI with counter=0.
  - HI: same as LO with the high-half address, then go to DONE.
  - DONE: exactly one cycle, then IDLE unconditionally. The same request must not retrigger, because the upstream register advances at the end of DONE.
- SRAM drive:
  - In LO/HI on a read: oe_n=0, we_n=1.
  - In LO/HI on a write: we_n=0, oe_n=1, sram_wdata = val_rm_in[15:0] in LO and val_rm_in[31:16] in HI.
  - sram_addr holds stable for the whole half-access.
  - Outside LO/HI: we_n=oe_n=1.
- Read capture: on the last cycle of LO (counter=WAIT_CYCLES−1), sram_rdata is latched into the low half of the read buffer. On the last cycle of HI, it is latched into the high half.
- freeze = (state==IDLE and (rd or wr)) or state==LO or state==HI.
  - A memory op freezes for 1+2·WAIT_CYCLES cycles (5 with the defaults).
- MEM/WB register:
  - When freeze=0, load wb_en, mem_read_en, alu_res, dest from the inputs, and mem_data from the read buffer. For a load in DONE, the buffer is complete at that point.
  - When freeze=1, insert a bubble: wb_en_out=0 and mem_read_en_out=0; the other fields hold.
  - Non-memory instructions pass through with 1-cycle latency and never freeze.
- Store with wb_en_in=1 is passed through unchanged; the decoder is responsible for not setting it.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2 bits: IDLE=0, LO=1, HI=2, DONE=3);
  - the BASE_ADDR default;
  - the register-index width of 4.
- One sub-module, sram_ctrl: the FSM, wait counter, address translation, SRAM pins, read buffer and freeze.
- The top level adds the MEM/WB register.

Test Plan:
- Non-memory op (wb_en=1, alu_res=0x0000_0055, dest=3) -> one cycle later wb_en_out=1, alu_res_out=0x55, dest_out=3; freeze never asserted.
- Store 0xDEAD_BEEF to addr 1028, WAIT_CYCLES=2 -> freeze high for 5 cycles.
  - sram_addr=2 with we_n=0 and wdata=0xBEEF for 2 cycles.
  - Then sram_addr=3 with wdata=0xDEAD for 2 cycles.
  - wb_en_out=0 throughout.
- Load from addr 1028 after that store (SRAM model) -> freeze for 5 cycles with oe_n=0; after DONE, mem_data_out=0xDEAD_BEEF, mem_read_en_out=1.
- Back-to-back store then load to addr 1024 -> two separate 5-cycle freezes with one unfrozen DONE cycle between; no extra or retriggered access.
- Reset asserted in the 2nd cycle of HI during a store -> next cycle IDLE, we_n=1, freeze=0 (given no request on the inputs), all MEM/WB outputs 0.
- WAIT_CYCLES=1 load at addr 1024 -> sram_addr 0 then 1, one cycle each; freeze 3 cycles.
